// File: rtl/prot_stim_gen_if.sv
// Request and line bundle for the protocol stimulus generator.
// The master side drives the request; the slave side (the generator) drives status and lines.
interface prot_stim_gen_if #(
    parameter int MAX_BYTES = 2
);
    localparam int NBW = $clog2(MAX_BYTES + 1);

    logic                   strt;
    logic [1:0]             mode;
    logic [NBW-1:0]         nbytes;
    logic [8*MAX_BYTES-1:0] data;
    logic                   pos_edge;
    logic                   busy;
    logic                   done;
    logic                   tx;
    logic                   SS_n;
    logic                   SCLK;
    logic                   MOSI;

    modport master (
        output strt, mode, nbytes, data, pos_edge,
        input  busy, done, tx, SS_n, SCLK, MOSI
    );

    modport slave (
        input  strt, mode, nbytes, data, pos_edge,
        output busy, done, tx, SS_n, SCLK, MOSI
    );
endinterface

// File: rtl/prot_stim_gen.sv
// Multi-byte UART / SPI trigger stimulus generator.
// The lines are decoded from the registered state, so reset forces them idle at once.
module prot_stim_gen #(
    parameter int BAUD_DIV  = 868,
    parameter int SCLK_DIV  = 32,
    parameter int MAX_BYTES = 2
) (
    input logic              clk,
    input logic              rst_n,
    prot_stim_gen_if.slave   bus
);
    localparam int MAXDIV = (BAUD_DIV > SCLK_DIV) ? BAUD_DIV : SCLK_DIV;
    localparam int CW     = $clog2(MAXDIV);
    localparam int BW     = $clog2(8*MAX_BYTES + 1);
    localparam int NBW    = $clog2(MAX_BYTES + 1);
    localparam int DW     = 8*MAX_BYTES;

    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] SCLK_LAST = CW'(SCLK_DIV - 1);
    localparam logic [CW-1:0] HALF      = CW'(SCLK_DIV / 2);
    localparam logic [CW-1:0] HALF_LAST = CW'(SCLK_DIV / 2 - 1);

    typedef enum logic [2:0] {
        IDLE, UART_BIT, SPI_FP, SPI_BIT, SPI_BP, FIN
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   bidx_q, bidx_d;
    logic [BW-1:0]   nbits_q, nbits_d;
    logic [3:0]      fpos_q, fpos_d;
    logic [DW-1:0]   data_q, data_d;
    logic            pos_q, pos_d;

    logic [NBW-1:0]  nb_eff;
    logic [BW-1:0]   req_bits;
    logic            req_null;
    logic            cur_bit;
    logic            busy_c, done_c, tx_c, ss_n_c, sclk_c, mosi_c;

    assign nb_eff   = (bus.nbytes > NBW'(MAX_BYTES)) ? NBW'(MAX_BYTES) : bus.nbytes;
    assign req_bits = BW'(nb_eff) << 3;
    assign req_null = (req_bits == '0) || !((bus.mode == 2'b01) || (bus.mode == 2'b10));
    // Payload bit addressed by the bit index; an out-of-range index reads 0.
    assign cur_bit  = |(data_q & (DW'(1) << bidx_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bidx_q  <= '0;
            nbits_q <= '0;
            fpos_q  <= '0;
            data_q  <= '0;
            pos_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bidx_q  <= bidx_d;
            nbits_q <= nbits_d;
            fpos_q  <= fpos_d;
            data_q  <= data_d;
            pos_q   <= pos_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bidx_d  = bidx_q;
        nbits_d = nbits_q;
        fpos_d  = fpos_q;
        data_d  = data_q;
        pos_d   = pos_q;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        tx_c    = 1'b1;
        ss_n_c  = 1'b1;
        sclk_c  = 1'b1;
        mosi_c  = 1'b0;

        unique case (state_q)
            // FIN doubles as an idle cycle so a request in the done cycle chains directly.
            IDLE, FIN: begin
                done_c  = (state_q == FIN);
                state_d = IDLE;
                if (bus.strt) begin
                    data_d  = bus.data;
                    pos_d   = bus.pos_edge;
                    nbits_d = req_bits;
                    cnt_d   = '0;
                    fpos_d  = '0;
                    if (req_null) begin
                        state_d = FIN;
                    end else if (bus.mode == 2'b01) begin
                        state_d = UART_BIT;
                        bidx_d  = '0;
                    end else begin
                        state_d = SPI_FP;
                        bidx_d  = req_bits - BW'(1);
                    end
                end
            end

            UART_BIT: begin
                busy_c = 1'b1;
                if (fpos_q == 4'd0)      tx_c = 1'b0;
                else if (fpos_q == 4'd9) tx_c = 1'b1;
                else                     tx_c = cur_bit;
                if (cnt_q == BAUD_LAST) begin
                    cnt_d = '0;
                    if (fpos_q == 4'd9) begin
                        fpos_d = '0;
                        if (bidx_q == nbits_q) state_d = FIN;
                    end else begin
                        fpos_d = fpos_q + 4'd1;
                        if (fpos_q != 4'd0) bidx_d = bidx_q + BW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            SPI_FP: begin
                busy_c = 1'b1;
                ss_n_c = 1'b0;
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = SPI_BIT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            SPI_BIT: begin
                busy_c = 1'b1;
                ss_n_c = 1'b0;
                mosi_c = cur_bit;
                sclk_c = pos_q ? (cnt_q >= HALF) : (cnt_q < HALF);
                if (cnt_q == SCLK_LAST) begin
                    cnt_d = '0;
                    if (bidx_q == '0) state_d = SPI_BP;
                    else              bidx_d  = bidx_q - BW'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            SPI_BP: begin
                busy_c = 1'b1;
                ss_n_c = 1'b0;
                mosi_c = cur_bit;
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.busy = busy_c;
    assign bus.done = done_c;
    assign bus.tx   = tx_c;
    assign bus.SS_n = ss_n_c;
    assign bus.SCLK = sclk_c;
    assign bus.MOSI = mosi_c;
endmodule

// File: tb/tb_prot_stim_gen.sv
// Bench for prot_stim_gen: per-cycle comparison against a waveform model built from
// the protocol rules, plus receiver-style decode of the serial payload.
module tb_prot_stim_gen;
    localparam int BAUD = 4;
    localparam int SDIV = 4;
    localparam int MAXB = 2;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    prot_stim_gen_if #(.MAX_BYTES(MAXB)) bus ();

    prot_stim_gen #(.BAUD_DIV(BAUD), .SCLK_DIV(SDIV), .MAX_BYTES(MAXB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic busy;
        logic done;
        logic tx;
        logic ss_n;
        logic sclk;
        logic mosi;
    } obs_t;

    typedef struct {
        logic [1:0]  mode;
        logic [1:0]  nbytes;
        logic [15:0] data;
        logic        pos;
        int          exp_len;
        logic [15:0] exp_word;
        int          exp_edges;
    } vec_t;

    obs_t exp_q[$];

    function automatic obs_t mk(input logic b, d, t, s, c, m);
        obs_t o;
        o.busy = b; o.done = d; o.tx = t; o.ss_n = s; o.sclk = c; o.mosi = m;
        return o;
    endfunction

    function automatic obs_t sample();
        return mk(bus.busy, bus.done, bus.tx, bus.SS_n, bus.SCLK, bus.MOSI);
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h exp=%0h", nm, idx, got, exp);
        end
    endtask

    // Expected line activity, one entry per cycle starting the cycle after strt is taken.
    function automatic void build_model(input logic [1:0] md, input logic [1:0] nb,
                                        input logic [15:0] dt, input logic pv);
        int n, nb8, h, fr, bp, k, ph;
        logic b, sc;
        exp_q.delete();
        n = (int'(nb) > MAXB) ? MAXB : int'(nb);
        if (n != 0 && md == 2'b01) begin
            for (int c = 0; c < 10*BAUD*n; c++) begin
                fr = c / (10*BAUD);
                bp = (c / BAUD) % 10;
                b  = (bp == 0) ? 1'b0 : (bp == 9) ? 1'b1 : dt[8*fr + bp - 1];
                exp_q.push_back(mk(1, 0, b, 1, 1, 0));
            end
        end else if (n != 0 && md == 2'b10) begin
            h   = SDIV / 2;
            nb8 = 8 * n;
            for (int c = 0; c < SDIV*(nb8+1); c++) begin
                if (c < h) begin
                    exp_q.push_back(mk(1, 0, 1, 0, 1, 0));
                end else if (c < h + nb8*SDIV) begin
                    k  = (c - h) / SDIV;
                    ph = (c - h) % SDIV;
                    b  = dt[nb8 - 1 - k];
                    sc = pv ? (ph >= h) : (ph < h);
                    exp_q.push_back(mk(1, 0, 1, 0, sc, b));
                end else begin
                    exp_q.push_back(mk(1, 0, 1, 0, 1, dt[0]));
                end
            end
        end
        exp_q.push_back(mk(0, 1, 1, 1, 1, 0));
    endfunction

    // Caller is just after a clock edge. With do_start=0 the request was already
    // raised in the previous done cycle. chain raises a UART request in the done cycle.
    task automatic run_xfer(input logic [1:0] md, input logic [1:0] nb, input logic [15:0] dt,
                            input logic pv, input bit do_start, input int poke_at,
                            input bit chain, input logic [15:0] chain_data,
                            output int blen, output logic [15:0] word, output int nedge);
        obs_t got;
        logic prev_sclk;
        int   fr, bp;
        build_model(md, nb, dt, pv);
        if (do_start) begin
            bus.mode = md; bus.nbytes = nb; bus.data = dt; bus.pos_edge = pv; bus.strt = 1'b1;
        end
        blen = 0; word = '0; nedge = 0; prev_sclk = 1'b1;
        for (int j = 0; j < exp_q.size(); j++) begin
            @(posedge clk); #1;
            if (j == 0) bus.strt = 1'b0;
            if (j == poke_at) begin
                bus.mode = 2'b10; bus.nbytes = 2'd2; bus.data = 16'hFFFF;
                bus.pos_edge = ~pv; bus.strt = 1'b1;
            end
            if (j == poke_at + 1) bus.strt = 1'b0;
            got = sample();
            chk("cycle", j, 32'(got), 32'(exp_q[j]));
            if (got.busy) begin
                if (md == 2'b01 && (blen % BAUD) == BAUD/2) begin
                    fr = blen / (10*BAUD);
                    bp = (blen / BAUD) % 10;
                    if (bp >= 1 && bp <= 8) begin
                        word[8*fr + bp - 1] = got.tx;
                        nedge++;
                    end
                end
                if (md == 2'b10 && ((pv && !prev_sclk && got.sclk) || (!pv && prev_sclk && !got.sclk))) begin
                    word = {word[14:0], got.mosi};
                    nedge++;
                end
                blen++;
            end
            prev_sclk = got.sclk;
            if (chain && j == exp_q.size() - 1) begin
                bus.mode = 2'b01; bus.nbytes = 2'd1; bus.data = chain_data;
                bus.pos_edge = 1'b0; bus.strt = 1'b1;
            end
        end
        if (!chain) begin
            @(posedge clk); #1;
            chk("idle_after", 0, 32'(sample()), 32'(mk(0, 0, 1, 1, 1, 0)));
        end
    endtask

    vec_t        vt[8];
    int          blen, nedge;
    logic [15:0] word;

    initial begin
        vt[0] = '{2'b01, 2'd1, 16'h0096, 1'b0, 40, 16'h0096, 8};
        vt[1] = '{2'b10, 2'd2, 16'h6600, 1'b0, 68, 16'h6600, 16};
        vt[2] = '{2'b10, 2'd2, 16'h6600, 1'b1, 68, 16'h6600, 16};
        vt[3] = '{2'b01, 2'd0, 16'h1234, 1'b0, 0, 16'h0000, 0};
        vt[4] = '{2'b00, 2'd2, 16'hBEEF, 1'b0, 0, 16'h0000, 0};
        vt[5] = '{2'b11, 2'd1, 16'hBEEF, 1'b1, 0, 16'h0000, 0};
        vt[6] = '{2'b01, 2'd3, 16'hA55A, 1'b0, 80, 16'hA55A, 16};
        vt[7] = '{2'b10, 2'd1, 16'h12C3, 1'b0, 36, 16'h00C3, 8};

        rst_n = 1'b0;
        bus.strt = 1'b0; bus.mode = 2'b00; bus.nbytes = '0; bus.data = '0; bus.pos_edge = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("reset_state", 0, 32'(sample()), 32'(mk(0, 0, 1, 1, 1, 0)));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_xfer(vt[i].mode, vt[i].nbytes, vt[i].data, vt[i].pos, 1'b1, -1, 1'b0, 16'h0,
                     blen, word, nedge);
            chk("vec_len", i, 32'(blen), 32'(vt[i].exp_len));
            chk("vec_word", i, 32'(word), 32'(vt[i].exp_word));
            chk("vec_edges", i, 32'(nedge), 32'(vt[i].exp_edges));
        end

        // Request mid-frame is ignored; request in the done cycle chains a second frame.
        run_xfer(2'b01, 2'd1, 16'h0096, 1'b0, 1'b1, 15, 1'b1, 16'h003C, blen, word, nedge);
        chk("busy_prot_word", 0, 32'(word), 32'h96);
        chk("busy_prot_len", 0, 32'(blen), 32'd40);
        run_xfer(2'b01, 2'd1, 16'h003C, 1'b0, 1'b0, -1, 1'b0, 16'h0, blen, word, nedge);
        chk("b2b_word", 0, 32'(word), 32'h3C);
        chk("b2b_len", 0, 32'(blen), 32'd40);

        // Asynchronous reset in the middle of SPI bit 5.
        bus.mode = 2'b10; bus.nbytes = 2'd1; bus.data = 16'h00A5; bus.pos_edge = 1'b0; bus.strt = 1'b1;
        @(posedge clk); #1 bus.strt = 1'b0;
        repeat (SDIV/2 + 5*SDIV + 1) @(posedge clk);
        #1 chk("pre_reset_busy", 0, 32'({bus.busy, bus.SS_n}), 32'b10);
        #2 rst_n = 1'b0;
        #1 chk("async_abort", 0, 32'(sample()), 32'(mk(0, 0, 1, 1, 1, 0)));
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1 chk("held_reset", k, 32'(sample()), 32'(mk(0, 0, 1, 1, 1, 0)));
        end
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1 chk("no_done_after_reset", k, 32'(sample()), 32'(mk(0, 0, 1, 1, 1, 0)));
        end
        run_xfer(2'b01, 2'd1, 16'h005A, 1'b0, 1'b1, -1, 1'b0, 16'h0, blen, word, nedge);
        chk("post_reset_word", 0, 32'(word), 32'h5A);
        chk("post_reset_len", 0, 32'(blen), 32'd40);

        // Random requests, whole waveform compared against the model.
        for (int r = 0; r < 40; r++) begin
            run_xfer(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 16'($urandom),
                     1'($urandom_range(0, 1)), 1'b1, -1, 1'b0, 16'h0, blen, word, nedge);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
